// File: rtl/mlp_conv2d_status_collect.sv
// Status collector for a NUM_ROWS x NUM_COLS conv array: PIPE_STAGES+1 cycles input to output.
// No backpressure; aggregate done/count, sticky first error, duration and watchdog are all registered.
module mlp_conv2d_status_collect #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int PIPE_STAGES    = 2,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int N             = NUM_ROWS * NUM_COLS,
  localparam int DC_W          = $clog2(N + 1),
  localparam int IDX_W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N-1:0]     i_conv_done,
  input  logic [N-1:0]     i_error,
  input  logic [N-1:0]     i_enable_mask,
  input  logic             i_mode_any,
  input  logic             i_clear,
  output logic             o_conv_done,
  output logic             o_conv_done_oe,
  output logic             o_done_pulse,
  output logic [DC_W-1:0]  o_done_count,
  output logic             o_error,
  output logic             o_error_oe,
  output logic [IDX_W-1:0] o_error_idx,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_last_cycles
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_TOUT = 2'd2;

  localparam logic [CNT_W:0] TO_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);

  logic [N-1:0]     r_done_pipe [PIPE_STAGES];
  logic [N-1:0]     r_err_pipe  [PIPE_STAGES];
  logic [N-1:0]     w_done_m;
  logic [N-1:0]     w_err_m;
  logic             w_agg;
  logic [DC_W-1:0]  w_pop;
  logic [IDX_W-1:0] w_err_idx;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_to_hit;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_conv_done;
  logic             r_done_pulse;
  logic [DC_W-1:0]  r_done_count;
  logic             r_error;
  logic [IDX_W-1:0] r_error_idx;
  logic             r_timeout;
  logic [CNT_W-1:0] r_last;

  // Die-crossing flops; these reset too so stale status never leaks past a reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_done_pipe[s] <= '0;
        r_err_pipe[s]  <= '0;
      end
    end else begin
      r_done_pipe[0] <= i_conv_done;
      r_err_pipe[0]  <= i_error;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_done_pipe[s] <= r_done_pipe[s-1];
        r_err_pipe[s]  <= r_err_pipe[s-1];
      end
    end
  end

  assign w_done_m = r_done_pipe[PIPE_STAGES-1] & i_enable_mask;
  assign w_err_m  = r_err_pipe[PIPE_STAGES-1] & i_enable_mask;

  // Masked-off bits read as done for the AND; an empty mask never reports done.
  assign w_agg = (i_enable_mask != '0) &&
                 (i_mode_any ? (w_done_m != '0) : ((w_done_m | ~i_enable_mask) == '1));

  always_comb begin
    w_pop     = '0;
    w_err_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + DC_W'(w_done_m[i]);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (w_err_m[i]) w_err_idx = IDX_W'(i);
    end
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_cnt_sat = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
  assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_VAL);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_conv_done  <= 1'b0;
      r_done_pulse <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_conv_done  <= w_agg;
      r_done_pulse <= w_agg & ~r_conv_done;
      r_done_count <= w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_error     <= 1'b0;
      r_error_idx <= '0;
    end else if (!r_error && (w_err_m != '0)) begin
      r_error     <= 1'b1;
      r_error_idx <= w_err_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_last    <= '0;
    end else if (i_clear) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_agg) begin
            r_last  <= w_cnt_sat;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_sat;
            if (w_to_hit) begin
              r_state   <= S_TOUT;
              r_timeout <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_cnt <= '0;
          if (!w_agg) r_state <= S_RUN;
        end
        S_TOUT: begin
          r_state <= S_TOUT;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_conv_done    = r_conv_done;
  assign o_conv_done_oe = 1'b1;
  assign o_done_pulse   = r_done_pulse;
  assign o_done_count   = r_done_count;
  assign o_error        = r_error;
  assign o_error_oe     = 1'b1;
  assign o_error_idx    = r_error_idx;
  assign o_timeout      = r_timeout;
  assign o_last_cycles  = r_last;

endmodule

// File: tb/tb_mlp_conv2d_status_collect.sv
// Bench for mlp_conv2d_status_collect: directed plan steps then random traffic vs a behavioural model.
module tb_mlp_conv2d_status_collect;

  localparam int N  = 16;
  localparam int P  = 2;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_conv_done, i_error, i_enable_mask;
  logic        i_mode_any, i_clear;
  logic        o_conv_done, o_conv_done_oe, o_done_pulse, o_error, o_error_oe, o_timeout;
  logic [4:0]  o_done_count;
  logic [3:0]  o_error_idx;
  logic [23:0] o_last_cycles;

  always #5 clk = ~clk;

  mlp_conv2d_status_collect #(
    .NUM_ROWS(4), .NUM_COLS(4), .PIPE_STAGES(P), .CNT_W(24), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_conv_done(i_conv_done), .i_error(i_error),
    .i_enable_mask(i_enable_mask), .i_mode_any(i_mode_any), .i_clear(i_clear),
    .o_conv_done(o_conv_done), .o_conv_done_oe(o_conv_done_oe), .o_done_pulse(o_done_pulse),
    .o_done_count(o_done_count), .o_error(o_error), .o_error_oe(o_error_oe),
    .o_error_idx(o_error_idx), .o_timeout(o_timeout), .o_last_cycles(o_last_cycles)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what each output should show, plus the convolution phase.
  logic [15:0] hist_done[$];
  logic [15:0] hist_err[$];
  bit          m_done, m_pulse, m_err, m_tout;
  int          m_count, m_idx, m_last, m_elapsed;
  int          m_phase;  // 0 running, 1 finished, 2 timed out

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [15:0] dd, de, dm, em;
    bit agg;
    @(posedge clk);
    if (i_reset) begin
      hist_done.delete(); hist_err.delete();
      for (int k = 0; k < P; k++) begin
        hist_done.push_back(16'h0); hist_err.push_back(16'h0);
      end
      m_done = 0; m_pulse = 0; m_err = 0; m_tout = 0;
      m_count = 0; m_idx = 0; m_last = 0; m_elapsed = 0; m_phase = 0;
    end else begin
      dd = hist_done.pop_front(); de = hist_err.pop_front();
      hist_done.push_back(i_conv_done); hist_err.push_back(i_error);
      dm = dd & i_enable_mask;
      em = de & i_enable_mask;
      agg = (i_enable_mask != 0) && (i_mode_any ? (dm != 0) : (dm == i_enable_mask));
      m_pulse = agg && !m_done;
      m_done  = agg;
      m_count = $countones(dm);
      if (i_clear) begin
        m_err = 0; m_idx = 0; m_tout = 0; m_elapsed = 0; m_phase = 0;
      end else begin
        if (!m_err && em != 0) begin
          m_err = 1;
          for (int b = 15; b >= 0; b--) if (em[b]) m_idx = b;
        end
        if (m_phase == 0) begin
          if (agg) begin
            m_last = m_elapsed + 1; m_elapsed = 0; m_phase = 1;
          end else begin
            m_elapsed++;
            if (m_elapsed == TO) begin m_tout = 1; m_phase = 2; end
          end
        end else if (m_phase == 1) begin
          if (!agg) m_phase = 0;
        end
      end
    end
    #1;
    chk("conv_done", 32'(o_conv_done), 32'(m_done));
    chk("done_pulse", 32'(o_done_pulse), 32'(m_pulse));
    chk("done_count", 32'(o_done_count), 32'(m_count));
    chk("error", 32'(o_error), 32'(m_err));
    chk("error_idx", 32'(o_error_idx), 32'(m_idx));
    chk("timeout", 32'(o_timeout), 32'(m_tout));
    chk("last_cycles", 32'(o_last_cycles), 32'(m_last));
    chk("oe", {30'd0, o_conv_done_oe, o_error_oe}, 32'd3);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_conv_done = '0; i_error = '0; i_clear = 1'b0;
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_conv_done = '0; i_error = '0; i_enable_mask = 16'hFFFF;
    i_mode_any = 1'b0; i_clear = 1'b0;
    repeat (3) step();
    chk("rst_last", 32'(o_last_cycles), 32'd0);
    i_reset = 1'b0;

    // All done, mode 0, bits rising one per cycle from cycle 10
    repeat (9) step();
    for (int b = 0; b < 16; b++) begin
      i_conv_done[b] = 1'b1;
      step();
    end
    repeat (3) step();
    chk("t1_done", 32'(o_conv_done), 32'd1);
    chk("t1_count", 32'(o_done_count), 32'd16);

    // Mask and mode
    i_enable_mask = 16'h00F0; i_conv_done = 16'h00F0;
    repeat (4) step();
    chk("t2_and_done", 32'(o_conv_done), 32'd1);
    chk("t2_count", 32'(o_done_count), 32'd4);
    i_mode_any = 1'b1; i_conv_done = 16'h0010;
    repeat (4) step();
    chk("t2_any_done", 32'(o_conv_done), 32'd1);
    i_enable_mask = 16'h0000;
    repeat (4) step();
    chk("t2_empty_mask", 32'(o_conv_done), 32'd0);

    // Error capture
    i_enable_mask = 16'hFFFF; i_mode_any = 1'b0; i_conv_done = '0;
    i_error = 16'h0220; step(); i_error = '0; repeat (3) step();
    chk("t3_err", 32'(o_error), 32'd1);
    chk("t3_idx5", 32'(o_error_idx), 32'd5);
    i_error = 16'h0004; step(); i_error = '0; repeat (3) step();
    chk("t3_idx_held", 32'(o_error_idx), 32'd5);
    i_error = 16'h0008; step(); step();
    i_clear = 1'b1; step();
    chk("t3_cleared", 32'(o_error), 32'd0);
    i_clear = 1'b0; i_error = '0; step();
    chk("t3_recap", 32'(o_error), 32'd1);
    chk("t3_idx3", 32'(o_error_idx), 32'd3);
    repeat (3) step();

    // Timeout
    i_enable_mask = 16'hFFFF; i_mode_any = 1'b0;
    do_reset();
    repeat (99) step();
    chk("t4_before", 32'(o_timeout), 32'd0);
    step();
    chk("t4_at100", 32'(o_timeout), 32'd1);
    i_conv_done = 16'hFFFF; repeat (5) step();
    chk("t4_sticky", 32'(o_timeout), 32'd1);
    chk("t4_done_tracks", 32'(o_conv_done), 32'd1);
    i_conv_done = '0; repeat (4) step();
    i_clear = 1'b1; step(); i_clear = 1'b0;
    chk("t4_clear", 32'(o_timeout), 32'd0);
    repeat (99) step();
    chk("t4_restart_before", 32'(o_timeout), 32'd0);
    step();
    chk("t4_restart_at100", 32'(o_timeout), 32'd1);

    // Duration
    i_mode_any = 1'b1;
    do_reset();
    repeat (54) step();
    i_conv_done = 16'h0001; repeat (3) step();
    chk("t5_dur57", 32'(o_last_cycles), 32'd57);
    i_conv_done = '0; repeat (20) step();
    i_conv_done = 16'h0001; repeat (3) step();
    chk("t5_dur20", 32'(o_last_cycles), 32'd20);

    // Reset mid-run with error set and counter at 40
    i_mode_any = 1'b0; i_conv_done = '0;
    do_reset();
    i_error = 16'h0100; step(); i_error = '0;
    repeat (39) step();
    chk("t6_err_before", 32'(o_error), 32'd1);
    i_reset = 1'b1; step();
    chk("t6_err", 32'(o_error), 32'd0);
    chk("t6_idx", 32'(o_error_idx), 32'd0);
    chk("t6_last", 32'(o_last_cycles), 32'd57 - 32'd57);
    i_reset = 1'b0;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 29) == 0) i_enable_mask = 16'($urandom());
      if ($urandom_range(0, 19) == 0) i_enable_mask = 16'hFFFF;
      if ($urandom_range(0, 39) == 0) i_mode_any = ~i_mode_any;
      if ($urandom_range(0, 3) == 0) i_conv_done = i_conv_done ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) i_conv_done = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0;
      i_error = ($urandom_range(0, 14) == 0) ? 16'($urandom()) : 16'h0;
      i_clear = ($urandom_range(0, 29) == 0);
      i_reset = ($urandom_range(0, 199) == 0);
      step();
    end
    i_reset = 1'b0; i_clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
